// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns one load/store request into a req/gnt/rvalid
// data-bus transaction. Optional macro LSU_MISALIGN_TRAP_EN enables the misalignment trap.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      wl,
  input  logic            extend_sign,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            misaligned
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [31:0] LP_TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t          r_state;
  logic            r_is_load;
  logic [1:0]      r_wl;
  logic [1:0]      r_off;
  logic            r_sext;
  logic [31:0]     r_cnt;
  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_load_data;
  logic            r_load_valid;

  logic            w_req_in;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_ext;

  assign w_req_in = mem_read | mem_write;

  // Lane selection for stores; the low address bits a width cannot use are dropped.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = '0;
    if (wl[1]) begin
      w_be    = 4'b1111;
      w_wdata = store_data;
    end else if (wl[0]) begin
      w_be    = addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{store_data[15:0]}};
    end else begin
      w_be    = 4'b0001 << addr[1:0];
      w_wdata = {4{store_data[7:0]}};
    end
  end

  assign w_byte = dmem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = dmem_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load_ext = dmem_rdata;
    case (r_wl)
      2'b00:   w_load_ext = {{(XLEN-8){r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{(XLEN-16){r_sext & w_half[15]}}, w_half};
      default: w_load_ext = dmem_rdata;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misaligned;
  assign w_misalign = (wl == 2'b01 && addr[0]) || (wl[1] && addr[1:0] != 2'b00);
  assign misaligned = r_misaligned;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_is_load    <= 1'b0;
      r_wl         <= 2'b00;
      r_off        <= 2'b00;
      r_sext       <= 1'b0;
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be         <= 4'b0000;
      r_wdata      <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_load_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_req_in) begin
            r_is_load <= mem_read;
            r_wl      <= wl;
            r_off     <= addr[1:0];
            r_sext    <= extend_sign;
            r_cnt     <= '0;
            r_we      <= ~mem_read;
            r_addr    <= {addr[XLEN-1:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= w_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
            if (w_misalign) begin
              r_misaligned <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_req   <= 1'b1;
              r_state <= REQ;
            end
`else
            r_req   <= 1'b1;
            r_state <= REQ;
`endif
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            r_req   <= 1'b0;
            r_state <= r_is_load ? WAIT : DONE;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            r_load_data  <= w_load_ext;
            r_load_valid <= 1'b1;
            r_state      <= DONE;
          end else if (TIMEOUT > 0 && r_cnt == LP_TO_LAST) begin
            // A response that never arrives completes the load with zero data.
            r_load_data  <= '0;
            r_load_valid <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The request cycle itself must stall, so the IDLE term stays combinational.
  assign stall      = (r_state == IDLE && w_req_in) || r_state == REQ || r_state == WAIT;
  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected bus requests,
// load results, stall run lengths and misalignment strobes; a negedge monitor checks them.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, extend_sign = 1'b0;
  logic [1:0]  wl = 2'b00;
  logic [31:0] addr = '0, store_data = '0;
  logic        stall, load_valid, dmem_req, dmem_we, misaligned;
  logic [31:0] load_data, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  load_store_unit #(.XLEN(32), .TIMEOUT(0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .wl(wl), .extend_sign(extend_sign), .addr(addr), .store_data(store_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] ld_q[$];
  int          stall_q[$];
  int          mis_q[$];
  int          checks = 0;
  int          failures = 0;
  int          run = 0;
  bus_t        be_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    bus_t b;
    b.a = a; b.be = be; b.we = we; b.wd = wd;
    bus_q.push_back(b);
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (bus_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req actual=%h expected=none", dmem_addr);
        end else begin
          be_exp = bus_q[0];
          chk("dmem_addr", dmem_addr, be_exp.a);
          chk("dmem_be", {28'b0, dmem_be}, {28'b0, be_exp.be});
          chk("dmem_we", {31'b0, dmem_we}, {31'b0, be_exp.we});
          chk("dmem_wdata", dmem_wdata, be_exp.wd);
          if (dmem_gnt) void'(bus_q.pop_front());
        end
      end
      if (load_valid) begin
        if (ld_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_load_valid actual=%h expected=none", load_data);
        end else begin
          chk("load_data", load_data, ld_q.pop_front());
        end
      end
      if (misaligned) begin
        if (mis_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_misaligned actual=1 expected=0");
        end else begin
          void'(mis_q.pop_front());
          chk("misaligned_no_lv", {31'b0, load_valid}, 32'd0);
        end
      end
      if (stall) begin
        run++;
      end else if (run > 0) begin
        if (stall_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_stall_run actual=%0d expected=none", run);
        end else begin
          chk("stall_cycles", run, stall_q.pop_front());
        end
        run = 0;
      end
    end
  end

  // Driver plus memory responder: gnt in the k-th REQ cycle, rvalid in the m-th WAIT cycle.
  task automatic do_acc(input logic rd, input logic wr, input logic [1:0] w, input logic sx,
                        input logic [31:0] a, input logic [31:0] sd, input int k, input int m,
                        input logic [31:0] rdat);
    int  req_cyc, wait_cyc;
    bit  granted, done;
    req_cyc = 0; wait_cyc = 0; granted = 0; done = 0;
    mem_read = rd; mem_write = wr; wl = w; extend_sign = sx; addr = a; store_data = sd;
    for (int n = 0; n < 60 && !done; n++) begin
      @(posedge clk); #1;
      if (dmem_gnt) granted = 1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      if (!stall) done = 1;
      else if (dmem_req) begin
        req_cyc++;
        if (req_cyc >= k) dmem_gnt = 1'b1;
      end else if (granted) begin
        wait_cyc++;
        if (wait_cyc >= m) begin dmem_rvalid = 1'b1; dmem_rdata = rdat; end
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL access_timeout actual=stalled expected=done addr=%h", a);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_load_valid", {31'b0, load_valid}, 32'd0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_dmem_be", {28'b0, dmem_be}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // sb 0x1003
    push_bus(32'h1000, 4'b1000, 1'b1, 32'hDDDDDDDD); stall_q.push_back(2);
    do_acc(0, 1, 2'b00, 0, 32'h1003, 32'hAABBCCDD, 1, 1, 32'h0);
    // lb / lbu 0x2001
    push_bus(32'h2000, 4'b0010, 1'b0, 32'h0); stall_q.push_back(3); ld_q.push_back(32'hFFFFFF80);
    do_acc(1, 0, 2'b00, 1, 32'h2001, 32'h0, 1, 1, 32'h00008000);
    push_bus(32'h2000, 4'b0010, 1'b0, 32'h0); stall_q.push_back(3); ld_q.push_back(32'h00000080);
    do_acc(1, 0, 2'b00, 0, 32'h2001, 32'h0, 1, 1, 32'h00008000);
    // lhu / lh 0x2002
    push_bus(32'h2000, 4'b1100, 1'b0, 32'h0); stall_q.push_back(3); ld_q.push_back(32'h0000BEEF);
    do_acc(1, 0, 2'b01, 0, 32'h2002, 32'h0, 1, 1, 32'hBEEF1234);
    push_bus(32'h2000, 4'b1100, 1'b0, 32'h0); stall_q.push_back(3); ld_q.push_back(32'hFFFFBEEF);
    do_acc(1, 0, 2'b01, 1, 32'h2002, 32'h0, 1, 1, 32'hBEEF1234);
    // lw with back-pressure: gnt in 3rd REQ cycle, rvalid in 2nd WAIT cycle
    push_bus(32'h2004, 4'b1111, 1'b0, 32'h0); stall_q.push_back(6); ld_q.push_back(32'h12345678);
    do_acc(1, 0, 2'b10, 1, 32'h2004, 32'h0, 3, 2, 32'h12345678);
    // sh 0x1002
    push_bus(32'h1000, 4'b1100, 1'b1, 32'hCAFECAFE); stall_q.push_back(2);
    do_acc(0, 1, 2'b01, 0, 32'h1002, 32'h0000CAFE, 1, 1, 32'h0);
    // wl=11 treated as word, zero-extend flag irrelevant
    push_bus(32'h2008, 4'b1111, 1'b0, 32'h0); stall_q.push_back(3); ld_q.push_back(32'hCAFEF00D);
    do_acc(1, 0, 2'b11, 0, 32'h2008, 32'h0, 1, 1, 32'hCAFEF00D);
    // lb top lane, positive byte
    push_bus(32'h2000, 4'b1000, 1'b0, 32'h0); stall_q.push_back(4); ld_q.push_back(32'h0000007F);
    do_acc(1, 0, 2'b00, 1, 32'h2003, 32'h0, 2, 1, 32'h7F000000);
`ifdef LSU_MISALIGN_TRAP_EN
    stall_q.push_back(1); mis_q.push_back(1);
    do_acc(0, 1, 2'b10, 0, 32'h3002, 32'h11223344, 1, 1, 32'h0);
    stall_q.push_back(1); mis_q.push_back(1);
    do_acc(1, 0, 2'b01, 1, 32'h2003, 32'h0, 1, 1, 32'h80017777);
`else
    push_bus(32'h3000, 4'b1111, 1'b1, 32'h11223344); stall_q.push_back(2);
    do_acc(0, 1, 2'b10, 0, 32'h3002, 32'h11223344, 1, 1, 32'h0);
    push_bus(32'h2000, 4'b1100, 1'b0, 32'h0); stall_q.push_back(3); ld_q.push_back(32'hFFFF8001);
    do_acc(1, 0, 2'b01, 1, 32'h2003, 32'h0, 1, 1, 32'h80017777);
`endif

    // Reset in WAIT, then a stray rvalid
    push_bus(32'h2000, 4'b1111, 1'b0, 32'h0); stall_q.push_back(3);
    mem_read = 1'b1; wl = 2'b10; extend_sign = 1'b0; addr = 32'h2000; store_data = '0;
    @(posedge clk); #1; dmem_gnt = 1'b1;
    @(posedge clk); #1; dmem_gnt = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0; mem_read = 1'b0;
    #1 chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    chk("rst_mid_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1; dmem_rvalid = 1'b0;
    chk("stray_rvalid_load_valid", {31'b0, load_valid}, 32'd0);
    chk("stray_rvalid_stall", {31'b0, stall}, 32'd0);
    chk("stray_rvalid_load_data", load_data, 32'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("ld_q_empty", ld_q.size(), 32'd0);
    chk("stall_q_empty", stall_q.size(), 32'd0);
    chk("mis_q_empty", mis_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
